// File: rtl/alu_issue_stage.sv
// Two-entry issue buffer between decode and ALU16bit: operands are selected,
// sanitised and stored at accept time, then presented in strict FIFO order.
module alu_issue_stage (
   input  logic        clk,
   input  logic        reset,
   input  logic        inValid,
   output logic        inReady,
   input  logic [3:0]  funct,
   input  logic [1:0]  srcASel,
   input  logic [1:0]  srcBSel,
   input  logic [15:0] regA,
   input  logic [15:0] regB,
   input  logic [15:0] pc,
   input  logic [7:0]  imm,
   output logic        outValid,
   input  logic        outReady,
   output logic [3:0]  aluOp,
   output logic [15:0] aIn,
   output logic [15:0] bIn,
   output logic [1:0]  count,
   output logic        illegalOp
);

   typedef struct packed {
      logic [3:0]  op;
      logic [15:0] a;
      logic [15:0] b;
   } entry_t;

   localparam entry_t EMPTY_ENTRY = '{op: 4'b0000, a: 16'h0000, b: 16'h0000};

   entry_t     head_r;
   entry_t     tail_r;
   entry_t     formed_s;
   logic [1:0] count_r;
   logic       illegal_r;
   logic       illegal_s;
   logic       push_s;
   logic       pop_s;
   logic [15:0] a_sel_s;
   logic [15:0] b_sel_s;

   function automatic logic is_illegal(input logic [3:0] f);
      return (f >= 4'b1010) && (f <= 4'b1101);
   endfunction

   assign push_s = inValid && inReady;
   assign pop_s  = (count_r != 2'd0) && outReady;

   // Operand selection, shift-amount clamp, EQ0 and illegal-code sanitising
   always_comb begin
      a_sel_s   = 16'h0000;
      b_sel_s   = 16'h0000;
      formed_s  = EMPTY_ENTRY;
      illegal_s = is_illegal(funct);
      case (srcASel)
         2'd0:    a_sel_s = regA;
         2'd1:    a_sel_s = pc;
         default: a_sel_s = 16'h0000;
      endcase
      case (srcBSel)
         2'd0:    b_sel_s = regB;
         2'd1:    b_sel_s = {{8{imm[7]}}, imm};
         2'd2:    b_sel_s = {8'h00, imm};
         default: b_sel_s = 16'd2;
      endcase
      if (illegal_s) begin
         formed_s = EMPTY_ENTRY;
      end else begin
         formed_s.op = funct;
         formed_s.a  = a_sel_s;
         case (funct)
            4'b0101, 4'b0110: formed_s.b = (b_sel_s > 16'd16) ? 16'd16 : b_sel_s;
            4'b1110:          formed_s.b = 16'h0000;
            default:          formed_s.b = b_sel_s;
         endcase
      end
   end

   // FIFO storage: head is always the presented entry and is cleared when empty
   always_ff @(posedge clk) begin
      if (reset) begin
         head_r  <= EMPTY_ENTRY;
         tail_r  <= EMPTY_ENTRY;
         count_r <= 2'd0;
      end else begin
         case (count_r)
            2'd0: begin
               if (push_s) begin
                  head_r  <= formed_s;
                  count_r <= 2'd1;
               end
            end
            2'd1: begin
               if (push_s && pop_s) begin
                  head_r <= formed_s;
               end else if (push_s) begin
                  tail_r  <= formed_s;
                  count_r <= 2'd2;
               end else if (pop_s) begin
                  head_r  <= EMPTY_ENTRY;
                  count_r <= 2'd0;
               end
            end
            2'd2: begin
               if (pop_s) begin
                  head_r  <= tail_r;
                  tail_r  <= EMPTY_ENTRY;
                  count_r <= 2'd1;
               end
            end
            default: begin
               head_r  <= EMPTY_ENTRY;
               tail_r  <= EMPTY_ENTRY;
               count_r <= 2'd0;
            end
         endcase
      end
   end

   // Sticky record of any accepted illegal operation code
   always_ff @(posedge clk) begin
      if (reset) begin
         illegal_r <= 1'b0;
      end else if (push_s && illegal_s) begin
         illegal_r <= 1'b1;
      end
   end

   assign inReady   = (count_r != 2'd2) && !reset;
   assign outValid  = (count_r != 2'd0);
   assign count     = count_r;
   assign aluOp     = head_r.op;
   assign aIn       = head_r.a;
   assign bIn       = head_r.b;
   assign illegalOp = illegal_r;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: accepted ops queue their expected
// ALU inputs; a monitor compares every handshake-completed output.
module tb_alu_issue_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        inValid;
   logic        inReady;
   logic [3:0]  funct;
   logic [1:0]  srcASel;
   logic [1:0]  srcBSel;
   logic [15:0] regA;
   logic [15:0] regB;
   logic [15:0] pc;
   logic [7:0]  imm;
   logic        outValid;
   logic        outReady;
   logic [3:0]  aluOp;
   logic [15:0] aIn;
   logic [15:0] bIn;
   logic [1:0]  count;
   logic        illegalOp;

   int checks = 0;
   int errors = 0;
   logic [35:0] exp_q[$];

   alu_issue_stage dut (
      .clk(clk), .reset(reset), .inValid(inValid), .inReady(inReady),
      .funct(funct), .srcASel(srcASel), .srcBSel(srcBSel),
      .regA(regA), .regB(regB), .pc(pc), .imm(imm),
      .outValid(outValid), .outReady(outReady),
      .aluOp(aluOp), .aIn(aIn), .bIn(bIn), .count(count), .illegalOp(illegalOp)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every completed output transfer must match the oldest expectation
   initial begin
      logic [35:0] e;
      forever begin
         @(negedge clk);
         if (reset === 1'b0 && outValid === 1'b1 && outReady === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: got %h expected none", {aluOp, aIn, bIn});
            end else begin
               e = exp_q.pop_front();
               chk("fifo_out", {aluOp, aIn, bIn}, e);
            end
         end
      end
   end

   task automatic set_op(input logic [3:0] f, input logic [1:0] as, input logic [1:0] bs,
                         input logic [15:0] ra, input logic [15:0] rb,
                         input logic [15:0] p, input logic [7:0] im);
      funct = f; srcASel = as; srcBSel = bs;
      regA = ra; regB = rb; pc = p; imm = im;
   endtask

   // Offer one op (called just after a rising edge); returns just after its accept edge
   task automatic issue(input logic [3:0] f, input logic [1:0] as, input logic [1:0] bs,
                        input logic [15:0] ra, input logic [15:0] rb,
                        input logic [15:0] p, input logic [7:0] im,
                        input logic [3:0] eo, input logic [15:0] ea, input logic [15:0] eb);
      logic accepted;
      accepted = 1'b0;
      set_op(f, as, bs, ra, rb, p, im);
      inValid = 1'b1;
      for (int i = 0; i < 20 && !accepted; i++) begin
         @(negedge clk);
         if (inReady === 1'b1) begin
            exp_q.push_back({eo, ea, eb});
            accepted = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      inValid = 1'b0;
      if (!accepted) begin
         checks++;
         errors++;
         $display("FAIL issue_timeout: got inReady 0 expected 1 within 20 cycles");
      end
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      reset = 1'b1; inValid = 1'b0; outReady = 1'b0;
      set_op(4'h0, 2'd0, 2'd0, 16'h0, 16'h0, 16'h0, 8'h00);
      cycles(3);
      @(negedge clk);
      chk("reset_inReady", {35'd0, inReady}, 36'd0);
      chk("reset_state", {count, outValid, illegalOp, aluOp, aIn, bIn}, 40'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("post_reset_inReady", {35'd0, inReady}, 36'd1);
      chk("post_reset_state", {count, outValid, aluOp, aIn, bIn}, 39'd0);
      @(posedge clk); #1;

      // basic pass-through with one-cycle latency
      outReady = 1'b1;
      issue(4'b0000, 2'd0, 2'd0, 16'd13, 16'd24, 16'h0, 8'h00, 4'b0000, 16'd13, 16'd24);
      @(negedge clk);
      chk("latency_valid", {34'd0, count, outValid} , {34'd0, 2'd1, 1'b1});
      @(posedge clk); #1;
      @(negedge clk);
      chk("drained_count", {33'd0, count, outValid}, 36'd0);
      @(posedge clk); #1;

      // back-pressure: two fill the buffer, the third is refused
      outReady = 1'b0;
      issue(4'b0001, 2'd0, 2'd0, 16'h1111, 16'h2222, 16'h0, 8'h00, 4'b0001, 16'h1111, 16'h2222);
      issue(4'b0010, 2'd0, 2'd0, 16'h3333, 16'h4444, 16'h0, 8'h00, 4'b0010, 16'h3333, 16'h4444);
      set_op(4'b0011, 2'd0, 2'd0, 16'h5555, 16'h6666, 16'h0, 8'h00);
      inValid = 1'b1;
      @(negedge clk);
      chk("full_inReady", {35'd0, inReady}, 36'd0);
      chk("full_count", {34'd0, count}, 36'd2);
      @(posedge clk); #1;
      @(negedge clk);
      chk("stall_hold", {aluOp, aIn, bIn}, {4'b0001, 16'h1111, 16'h2222});
      chk("stall_count", {34'd0, count}, 36'd2);
      @(posedge clk); #1;
      inValid = 1'b0;
      outReady = 1'b1;
      cycles(4);
      @(negedge clk);
      chk("drain_empty", {33'd0, count, outValid}, 36'd0);
      @(posedge clk); #1;

      // operand formation
      issue(4'b0111, 2'd0, 2'd1, 16'h0003, 16'h0, 16'h0, 8'hF1, 4'b0111, 16'h0003, 16'hFFF1);
      issue(4'b0111, 2'd0, 2'd2, 16'h0003, 16'h0, 16'h0, 8'hF1, 4'b0111, 16'h0003, 16'h00F1);
      issue(4'b0111, 2'd1, 2'd3, 16'h0003, 16'h0, 16'h0040, 8'h00, 4'b0111, 16'h0040, 16'h0002);
      issue(4'b0101, 2'd0, 2'd0, 16'h0001, 16'h0025, 16'h0, 8'h00, 4'b0101, 16'h0001, 16'h0010);
      issue(4'b0110, 2'd0, 2'd0, 16'h0001, 16'h0007, 16'h0, 8'h00, 4'b0110, 16'h0001, 16'h0007);
      issue(4'b0101, 2'd2, 2'd0, 16'hBEEF, 16'h0010, 16'h0, 8'h00, 4'b0101, 16'h0000, 16'h0010);
      issue(4'b1110, 2'd0, 2'd0, 16'h0055, 16'h1234, 16'h0, 8'h00, 4'b1110, 16'h0055, 16'h0000);
      issue(4'b1111, 2'd3, 2'd1, 16'hAAAA, 16'h0, 16'h0, 8'h7F, 4'b1111, 16'h0000, 16'h007F);
      @(negedge clk);
      chk("no_illegal_yet", {35'd0, illegalOp}, 36'd0);
      @(posedge clk); #1;

      // illegal op sanitised, flag sticky
      issue(4'b1011, 2'd0, 2'd0, 16'd5, 16'd6, 16'h0, 8'h00, 4'b0000, 16'd0, 16'd0);
      @(negedge clk);
      chk("illegal_set", {35'd0, illegalOp}, 36'd1);
      @(posedge clk); #1;
      cycles(3);
      @(negedge clk);
      chk("illegal_sticky", {35'd0, illegalOp}, 36'd1);
      chk("outReady_empty_noop", {34'd0, count}, 36'd0);
      @(posedge clk); #1;

      // reset with a full buffer and an op on offer
      outReady = 1'b0;
      issue(4'b0011, 2'd0, 2'd0, 16'h0A0A, 16'h0B0B, 16'h0, 8'h00, 4'b0011, 16'h0A0A, 16'h0B0B);
      issue(4'b0100, 2'd0, 2'd0, 16'h0C0C, 16'h0D0D, 16'h0, 8'h00, 4'b0100, 16'h0C0C, 16'h0D0D);
      set_op(4'b1000, 2'd0, 2'd0, 16'h0E0E, 16'h0F0F, 16'h0, 8'h00);
      inValid = 1'b1;
      outReady = 1'b1;
      reset = 1'b1;
      @(posedge clk); #1;
      exp_q.delete();
      @(negedge clk);
      chk("reset_flush", {count, outValid, illegalOp, aluOp, aIn, bIn}, 40'd0);
      @(posedge clk); #1;
      inValid = 1'b0;
      reset = 1'b0;
      cycles(2);
      @(negedge clk);
      chk("offer_not_captured", {33'd0, count, outValid}, 36'd0);
      chk("queue_empty", 36'(exp_q.size()), 36'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
